// File: rtl/ps2_pkg.sv
// Shared key indices, scancodes, receiver state encoding and event record for the PS/2 key controller.
package ps2_pkg;

  localparam int unsigned NUM_KEYS = 7;

  localparam logic [2:0] KEY_UP    = 3'd0;
  localparam logic [2:0] KEY_DOWN  = 3'd1;
  localparam logic [2:0] KEY_LEFT  = 3'd2;
  localparam logic [2:0] KEY_RIGHT = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;
  localparam logic [2:0] KEY_ENTER = 3'd5;
  localparam logic [2:0] KEY_ESC   = 3'd6;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic [2:0] key;
    logic       make;
  } key_evt_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] key;
  } key_map_t;

  // Extended and plain code spaces overlap numerically, so ext selects the table.
  function automatic key_map_t map_code(input logic ext, input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b1;
    m.key = KEY_UP;
    if (ext) begin
      case (code)
        SC_UP:    m.key = KEY_UP;
        SC_DOWN:  m.key = KEY_DOWN;
        SC_LEFT:  m.key = KEY_LEFT;
        SC_RIGHT: m.key = KEY_RIGHT;
        default:  m.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_SPACE: m.key = KEY_SPACE;
        SC_ENTER: m.key = KEY_ENTER;
        SC_ESC:   m.key = KEY_ESC;
        default:  m.hit = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 bit-level receiver: synchronizes the device lines, assembles 11-bit frames
// and emits one-cycle byte strobes or frame-error pulses.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC  = 20000,
  parameter int unsigned CHECK_PARITY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       r_clk_sync;
  logic [1:0]       r_dat_sync;
  logic             r_clk_prev;
  rx_state_e        r_state;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_par;
  logic             r_byte_valid;
  logic [7:0]       r_byte;
  logic             r_frame_err;

  logic w_fall;
  logic w_dat;
  logic w_timeout;
  logic w_par_bad;

  assign w_fall    = r_clk_prev & ~r_clk_sync[1];
  assign w_dat     = r_dat_sync[1];
  assign w_timeout = (r_state != RX_IDLE) && !w_fall &&
                     (r_idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_par_bad = (CHECK_PARITY != 0) && !(^{r_shift, r_par});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync   <= '1;
      r_dat_sync   <= '1;
      r_clk_prev   <= 1'b1;
      r_state      <= RX_IDLE;
      r_idle_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync   <= {r_dat_sync[0], i_ps2_dat};
      r_clk_prev   <= r_clk_sync[1];
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;

      if (w_fall || r_state == RX_IDLE) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      end

      if (w_timeout) begin
        r_state     <= RX_IDLE;
        r_frame_err <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          RX_IDLE: begin
            if (!w_dat) begin
              r_state   <= RX_DATA;
              r_bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= RX_PAR;
            end
          end
          RX_PAR: begin
            r_par   <= w_dat;
            r_state <= RX_STOP;
          end
          RX_STOP: begin
            r_state <= RX_IDLE;
            if (w_dat && !w_par_bad) begin
              r_byte_valid <= 1'b1;
              r_byte       <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte       = r_byte;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard controller: decodes E0/F0-prefixed scancodes for seven keys,
// tracks held state and queues make/release events in a 4-entry show-ahead FIFO.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC  = 20000,
  parameter int unsigned CHECK_PARITY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2Clk,
  input  logic                ps2Dat,
  output logic                evtValid,
  input  logic                evtReady,
  output logic [2:0]          evtKey,
  output logic                evtMake,
  output logic [NUM_KEYS-1:0] held,
  output logic                frameErr,
  output logic                evtOvfl
);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_frame_err;

  ps2_rx_frame #(
    .TIMEOUT_CYC  (TIMEOUT_CYC),
    .CHECK_PARITY (CHECK_PARITY)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .i_ps2_clk    (ps2Clk),
    .i_ps2_dat    (ps2Dat),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_frame_err  (w_frame_err)
  );

  logic                r_ext;
  logic                r_brk;
  logic [NUM_KEYS-1:0] r_held;

  key_map_t            w_map;
  logic                w_is_prefix;
  logic                w_push;
  key_evt_t            w_evt;
  logic [NUM_KEYS-1:0] w_held_nxt;

  assign w_map       = map_code(r_ext, w_byte);
  assign w_is_prefix = (w_byte == SC_EXT) || (w_byte == SC_BRK);

  // Held state follows the key even when the FIFO drops the event.
  always_comb begin
    w_push     = 1'b0;
    w_evt      = '0;
    w_held_nxt = r_held;
    if (w_byte_valid && !w_is_prefix && w_map.hit) begin
      if (!r_brk && !r_held[w_map.key]) begin
        w_held_nxt[w_map.key] = 1'b1;
        w_push                = 1'b1;
        w_evt                 = '{key: w_map.key, make: 1'b1};
      end else if (r_brk && r_held[w_map.key]) begin
        w_held_nxt[w_map.key] = 1'b0;
        w_push                = 1'b1;
        w_evt                 = '{key: w_map.key, make: 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_held <= '0;
    end else begin
      r_held <= w_held_nxt;
      if (w_frame_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_valid) begin
        if (w_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

  key_evt_t   r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       r_ovfl;

  logic     w_empty;
  logic     w_full;
  logic     w_pop;
  logic     w_wr;
  key_evt_t w_head;

  assign w_empty = (r_count == 3'd0);
  assign w_full  = (r_count == 3'd4);
  assign w_pop   = !w_empty && evtReady;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovfl   <= 1'b0;
    end else begin
      r_ovfl  <= w_push && w_full && !w_pop;
      r_count <= r_count + 3'(w_wr) - 3'(w_pop);
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_evt;
    end
  end

  assign evtValid = !w_empty;
  assign evtKey   = w_empty ? '0 : w_head.key;
  assign evtMake  = w_empty ? 1'b0 : w_head.make;
  assign held     = r_held;
  assign frameErr = w_frame_err;
  assign evtOvfl  = r_ovfl;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: 10 kHz PS/2 frames against a 400 kHz system clock.
`timescale 1ns/1ps
module tb_ps2_key_ctrl;

  localparam int unsigned TMO     = 200;
  localparam int unsigned QUARTER = 25000;
  localparam int unsigned HALF    = 50000;

  logic       clk;
  logic       rst;
  logic       ps2Clk;
  logic       ps2Dat;
  logic       evtValid;
  logic       evtReady;
  logic [2:0] evtKey;
  logic       evtMake;
  logic [6:0] held;
  logic       frameErr;
  logic       evtOvfl;

  ps2_key_ctrl #(
    .TIMEOUT_CYC  (TMO),
    .CHECK_PARITY (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2Clk   (ps2Clk),
    .ps2Dat   (ps2Dat),
    .evtValid (evtValid),
    .evtReady (evtReady),
    .evtKey   (evtKey),
    .evtMake  (evtMake),
    .held     (held),
    .frameErr (frameErr),
    .evtOvfl  (evtOvfl)
  );

  initial clk = 1'b0;
  always #1250 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int errs_seen = 0;
  int ovfl_seen = 0;
  logic [3:0] evq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (evtValid && evtReady) evq.push_back({evtKey, evtMake});
      if (frameErr) errs_seen++;
      if (evtOvfl) ovfl_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_evt(input string tag, input logic [2:0] k, input logic m);
    logic [3:0] got;
    got = (evq.size() > 0) ? evq.pop_front() : 4'hF;
    check(tag, {28'd0, got}, {28'd0, k, m});
  endtask

  task automatic ps2_bit(input logic b);
    ps2Dat = b;
    #(QUARTER);
    ps2Clk = 1'b0;
    #(HALF);
    ps2Clk = 1'b1;
    #(QUARTER);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_b, input logic par_bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ par_bad);
    ps2_bit(stop_b);
    ps2Dat = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b1, 1'b0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 evtReady = v;
  endtask

  int e0;

  initial begin
    #(500_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ps2Clk = 1'b1; ps2Dat = 1'b1; evtReady = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, evtValid}, 0);
    check("rst_key", {29'd0, evtKey}, 0);
    check("rst_held", {25'd0, held}, 0);
    check("rst_err_ovfl", {30'd0, frameErr, evtOvfl}, 0);
    @(posedge clk); #1 rst = 1'b0;
    set_ready(1'b1);

    // E0 75 -> up make
    send_good(8'hE0); send_good(8'h75);
    check("up_n", evq.size(), 1);
    expect_evt("up_make", 3'd0, 1'b1);
    check("up_held", {25'd0, held}, 32'h01);

    // E0 F0 75 -> up release
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    check("up_rel_n", evq.size(), 1);
    expect_evt("up_rel", 3'd0, 1'b0);
    check("up_rel_held", {25'd0, held}, 0);

    // typematic space
    send_good(8'h29); send_good(8'h29); send_good(8'h29);
    check("sp_n", evq.size(), 1);
    expect_evt("sp_make", 3'd4, 1'b1);
    check("sp_held", {25'd0, held}, 32'h10);
    send_good(8'hF0); send_good(8'h29);
    check("sp_rel_n", evq.size(), 1);
    expect_evt("sp_rel", 3'd4, 1'b0);

    // bad stop bit
    e0 = errs_seen;
    send_byte(8'h5A, 1'b0, 1'b0);
    check("stop_err", errs_seen - e0, 1);
    check("stop_noevt", evq.size(), 0);
    check("stop_held", {25'd0, held}, 0);
    send_good(8'h5A);
    expect_evt("ent_make", 3'd5, 1'b1);
    check("ent_held", {25'd0, held}, 32'h20);

    // parity error after F0 clears brk: following 5A is a repeat, not a release
    e0 = errs_seen;
    send_good(8'hF0);
    send_byte(8'h76, 1'b1, 1'b1);
    check("par_err", errs_seen - e0, 1);
    send_good(8'h5A);
    check("par_noevt", evq.size(), 0);
    check("par_held", {25'd0, held}, 32'h20);
    send_good(8'hF0); send_good(8'h5A);
    expect_evt("ent_rel", 3'd5, 1'b0);

    // overflow: five makes into a stalled 4-entry FIFO
    set_ready(1'b0);
    e0 = ovfl_seen;
    send_good(8'hE0); send_good(8'h75);
    send_good(8'hE0); send_good(8'h72);
    send_good(8'hE0); send_good(8'h6B);
    send_good(8'hE0); send_good(8'h74);
    send_good(8'h29);
    check("ovfl_cnt", ovfl_seen - e0, 1);
    check("ovfl_held", {25'd0, held}, 32'h1F);
    @(negedge clk);
    check("ovfl_head", {28'd0, evtValid, evtKey}, {28'd0, 1'b1, 3'd0});
    set_ready(1'b1);
    repeat (10) @(posedge clk);
    check("drain_n", evq.size(), 4);
    expect_evt("drain0", 3'd0, 1'b1);
    expect_evt("drain1", 3'd1, 1'b1);
    expect_evt("drain2", 3'd2, 1'b1);
    expect_evt("drain3", 3'd3, 1'b1);

    // timeout after 4 data bits
    e0 = errs_seen;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    ps2Dat = 1'b1;
    repeat (TMO + 50) @(posedge clk);
    check("tmo_err", errs_seen - e0, 1);
    check("tmo_noevt", evq.size(), 0);
    send_good(8'hF0); send_good(8'hE0); send_good(8'h75);
    expect_evt("tmo_idle", 3'd0, 1'b0);
    check("tmo_held", {25'd0, held}, 32'h1E);

    // queue a release, then reset mid-frame
    set_ready(1'b0);
    send_good(8'hF0); send_good(8'h29);
    @(negedge clk);
    check("pend_head", {27'd0, evtValid, evtKey, evtMake}, {27'd0, 1'b1, 3'd4, 1'b0});
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    ps2Dat = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mrst_out", {21'd0, evtValid, evtKey, evtMake, held, frameErr, evtOvfl}, 0);
    @(posedge clk); #1 rst = 1'b0;
    e0 = errs_seen;
    for (int i = 0; i < 7; i++) ps2_bit(1'b1);
    repeat (TMO + 20) @(posedge clk);
    check("mrst_ign", errs_seen - e0, 0);
    check("mrst_valid", {31'd0, evtValid}, 0);
    set_ready(1'b1);
    send_good(8'h29);
    expect_evt("mrst_make", 3'd4, 1'b1);
    check("mrst_held", {25'd0, held}, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 20000: number of clk cycles without a ps2Clk falling edge that aborts a partial frame.
REQ-002 Parameter CHECK_PARITY, default 0: 1 = enforce odd parity; 0 = ignore parity bit.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ps2Clk  in  1  PS/2 device clock, asynchronous to clk, idle high.
REQ-006 ps2Dat  in  1  PS/2 device data, asynchronous to clk, idle high.
REQ-007 evtValid  out  1  key event available at FIFO head.
REQ-008 evtReady  in  1  consumer accepts head event when evtValid&evtReady.
REQ-009 evtKey  out  3  key index: 0 up, 1 down, 2 left, 3 right, 4 space, 5 enter, 6 esc.
REQ-010 evtMake  out  1  1 = press, 0 = release.
REQ-011 held  out  7  current pressed state per key index, bit n = key n.
REQ-012 frameErr  out  1  one-cycle pulse on bad start/stop/parity or timeout.
REQ-013 evtOvfl  out  1  one-cycle pulse when an event is dropped on full FIFO.

Function
REQ-014 ps2Clk and ps2Dat SHALL pass through 2-FF synchronizers; a bit is sampled on the clk cycle the synchronized ps2Clk falls (1 then 0).
REQ-015 Frame FSM states IDLE, DATA, PAR, STOP: IDLE->DATA on falling edge with data 0; falling edge with data 1 in IDLE is ignored.
REQ-016 DATA captures 8 bits LSB first, then PAR captures parity, STOP captures stop bit and returns to IDLE.
REQ-017 Stop bit 0, or (CHECK_PARITY=1 and data+parity has even ones count) SHALL pulse frameErr and discard the byte.
REQ-018 Idle counter clears on every falling edge; in any state but IDLE, reaching TIMEOUT_CYC SHALL force IDLE and pulse frameErr.
REQ-019 A good byte SHALL be presented to the decoder exactly 1 cycle after the stop-bit edge is detected.
REQ-020 Decoder flags ext, brk: byte E0 sets ext; F0 sets brk; any other byte is a code and clears both flags after use.
REQ-021 Code map: ext&75 up, ext&72 down, ext&6B left, ext&74 right, !ext&29 space, !ext&5A enter, !ext&76 esc; anything else is discarded silently.
REQ-022 Mapped code with brk=0: if held[n]=0 set it and push make event; if already 1 (typematic repeat) no event.
REQ-023 Mapped code with brk=1: if held[n]=1 clear it and push release event; else no event.
REQ-024 frameErr SHALL also clear ext and brk.
REQ-025 Event FIFO: 4 entries of {key,make}, show-ahead; evtValid rises exactly 1 cycle after push.
REQ-026 Push on full without same-cycle pop SHALL drop the new event and pulse evtOvfl; push and pop in same cycle on full SHALL both succeed.
REQ-027 Pop on empty is ignored; evtKey/evtMake hold 0 when empty.

Reset
REQ-028 rst SHALL return frame FSM to IDLE, clear synchronizers to 1, counters, ext, brk, held, FIFO pointers; all outputs 0.
REQ-029 rst mid-frame SHALL discard the partial frame; subsequent bits before a fresh start bit are ignored.

Structure
REQ-030 Package ps2_pkg SHALL hold key index constants, scancode constants (E0, F0, map codes) and the event record type.
REQ-031 Bit-level receiver (REQ-014..019) SHALL be sub-module ps2_rx_frame; decoder and FIFO live in ps2_key_ctrl.

Verification
REQ-032 Frames E0,75 at 10 kHz ps2Clk -> one event key=0 make=1, held=0000001.
REQ-033 Then E0,F0,75 -> event key=0 make=0, held=0000000.
REQ-034 29 sent three times (typematic) with evtReady=1 -> exactly one make event key=4; F0,29 -> one release.
REQ-035 Frame with stop bit 0 after byte 5A -> frameErr pulse, no event, held unchanged; next valid 5A -> key=5 make.
REQ-036 evtReady=0, five distinct make events -> 4 queued, evtOvfl pulses once; draining returns them in order.
REQ-037 ps2Clk stops after 4 data bits for TIMEOUT_CYC cycles -> frameErr pulse, FSM IDLE; rst asserted mid-frame -> all outputs 0.
